// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode constants, field positions and immediate format lookup.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = ImmI;
      OPC_STORE:                      fmt = ImmS;
      OPC_BRANCH:                     fmt = ImmB;
      OPC_LUI, OPC_AUIPC:             fmt = ImmU;
      OPC_JAL:                        fmt = ImmJ;
      default:                        fmt = ImmNone;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; sign-extends to REG_W, unknown opcodes yield zero.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int unsigned REG_W = 32
) (
  input  logic [31:0]      instr,
  output logic [REG_W-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt(instr[6:0]))
      ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm32 = {instr[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = REG_W'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, busy-bit scoreboard and one-entry ID/EX register.
// Build option: define WB_BYPASS_EN to forward writeback data and issue in the writeback cycle.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter  int unsigned REG_COUNT = 32,
  parameter  int unsigned REG_W     = 32,
  localparam int unsigned REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [REG_W-1:0]     in_pc,
  output logic [REG_IDX_W-1:0] rf_rd_reg_a,
  output logic [REG_IDX_W-1:0] rf_rd_reg_b,
  input  logic [REG_W-1:0]     rf_rd_data_a,
  input  logic [REG_W-1:0]     rf_rd_data_b,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [REG_W-1:0]     wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_W-1:0]     out_pc,
  output logic [REG_W-1:0]     out_rs1_data,
  output logic [REG_W-1:0]     out_rs2_data,
  output logic [REG_W-1:0]     out_imm,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_we,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REG_IDX_W-1:0] rs1, rs2, rd;
  logic                 use1, use2, we;
  logic [REG_W-1:0]     imm;
  logic [REG_W-1:0]     rs1_data, rs2_data;

  logic [REG_COUNT-1:0] busy_q, busy_d, busy_src, wb_clr;
  logic                 hazard, fire;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[RD_LSB +: REG_IDX_W];
  assign funct3 = in_instr[FUNCT3_LSB +: 3];
  assign rs1    = in_instr[RS1_LSB +: REG_IDX_W];
  assign rs2    = in_instr[RS2_LSB +: REG_IDX_W];
  assign funct7 = in_instr[FUNCT7_LSB +: 7];

  assign rf_rd_reg_a = rs1;
  assign rf_rd_reg_b = rs2;

  assign use1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign use2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign we   = !(opcode inside {OPC_BRANCH, OPC_STORE}) && (rd != '0);

  decode_stage_imm_gen #(
    .REG_W (REG_W)
  ) u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  always_comb begin
    wb_clr = '0;
    if (wb_en && (wb_reg != '0)) wb_clr[wb_reg] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // A source retiring this cycle is taken straight from the writeback bus.
  assign busy_src = busy_q & ~wb_clr;
  assign rs1_data = (wb_en && (wb_reg == rs1) && (rs1 != '0)) ? wb_data : rf_rd_data_a;
  assign rs2_data = (wb_en && (wb_reg == rs2) && (rs2 != '0)) ? wb_data : rf_rd_data_b;
`else
  logic [REG_W-1:0] unused_wb_data;
  assign unused_wb_data = wb_data;
  assign busy_src = busy_q;
  assign rs1_data = rf_rd_data_a;
  assign rs2_data = rf_rd_data_b;
`endif

  assign hazard   = (use1 && busy_src[rs1]) || (use2 && busy_src[rs2]) || (we && busy_q[rd]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  // Set is applied last so it wins over a same-index clear.
  always_comb begin
    busy_d = busy_q & ~wb_clr;
    if (flush && out_valid && out_rd_we) busy_d[out_rd] = 1'b0;
    if (fire && we) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= imm;
      out_rd       <= rd;
      out_rd_we    <= we;
      out_opcode   <= opcode;
      out_funct3   <= funct3;
      out_funct7   <= funct7;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized traffic against a model.
module tb_decode_stage;
  import decode_stage_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_rd_reg_a, rf_rd_reg_b;
  logic [31:0] rf_rd_data_a, rf_rd_data_b;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  logic [31:0] rf_mem [32];
  assign rf_rd_data_a = rf_mem[rf_rd_reg_a];
  assign rf_rd_data_b = rf_mem[rf_rd_reg_b];

  always #5 clk = ~clk;

  decode_stage #(
    .REG_COUNT (32),
    .REG_W     (32)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .rf_rd_reg_a  (rf_rd_reg_a),
    .rf_rd_reg_b  (rf_rd_reg_b),
    .rf_rd_data_a (rf_rd_data_a),
    .rf_rd_data_b (rf_rd_data_b),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: expected ID/EX entry and set of registers with an in-flight writer.
  logic        m_valid, m_we;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_busy;
  logic [4:0]  m_rd;
  logic [6:0]  m_opc, m_f7;
  logic [2:0]  m_f3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Assembles an instruction from fields; imm is the architectural immediate value.
  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [6:0] f7,
                                      input logic [31:0] imm);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return {imm[11:0], rs1, f3, rd, opc};
      OPC_STORE:  return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      OPC_BRANCH: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      OPC_LUI, OPC_AUIPC: return {imm[31:12], rd, opc};
      OPC_JAL:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default:    return {f7, rs2, rs1, f3, rd, opc};
    endcase
  endfunction

  task automatic gen_rand(output logic [31:0] ins, output logic [31:0] imm);
    logic [6:0]  opc;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: opc = OPC_OP;     1: opc = OPC_OP_IMM; 2: opc = OPC_LOAD;  3: opc = OPC_STORE;
      4: opc = OPC_BRANCH; 5: opc = OPC_JAL;    6: opc = OPC_JALR;  7: opc = OPC_LUI;
      8: opc = OPC_AUIPC;  default: opc = 7'b0001111;
    endcase
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE: imm = {{20{r[11]}}, r[11:0]};
      OPC_BRANCH:         imm = {{19{r[12]}}, r[12:1], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {r[31:12], 12'b0};
      OPC_JAL:            imm = {{11{r[20]}}, r[20:1], 1'b0};
      default:            imm = 32'd0;
    endcase
    ins = enc(opc, 5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 7'($urandom), imm);
  endtask

  // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] eimm,
                      input logic [31:0] pc, input logic ordy, input logic fl, input logic wbe,
                      input logic [4:0] wr, input logic [31:0] wd,
                      output logic rdy, output logic fired);
    logic [6:0]  opc;
    logic [4:0]  a, b, d;
    logic        u1, u2, w, hz, exp_rdy, ba, bb;
    logic [31:0] da, db;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    wb_en = wbe; wb_reg = wr; wb_data = wd;
    opc = ins[6:0]; d = ins[11:7]; a = ins[19:15]; b = ins[24:20];
    u1 = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    u2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    w  = !(opc inside {OPC_BRANCH, OPC_STORE}) && d != 0;
    ba = m_busy[a] && !(BYPASS && wbe && wr == a);
    bb = m_busy[b] && !(BYPASS && wbe && wr == b);
    hz = (u1 && ba) || (u2 && bb) || (w && m_busy[d]);
    exp_rdy = (!m_valid || ordy) && !hz && !fl;
    da = (BYPASS && wbe && wr == a && a != 0) ? wd : rf_mem[a];
    db = (BYPASS && wbe && wr == b && b != 0) ? wd : rf_mem[b];
    #1;
    check_eq("in_ready", in_ready, exp_rdy);
    rdy = in_ready;
    fired = v && exp_rdy;
    @(posedge clk);
    if (wbe && wr != 0) m_busy[wr] = 1'b0;
    if (fl && m_valid && m_we) m_busy[m_rd] = 1'b0;
    if (fired && w) m_busy[d] = 1'b1;
    if (fired) begin
      m_valid = 1'b1; m_pc = pc; m_rs1 = da; m_rs2 = db; m_imm = eimm;
      m_rd = d; m_we = w; m_opc = opc; m_f3 = ins[14:12]; m_f7 = ins[31:25];
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    #1;
    if (wbe && wr != 0) rf_mem[wr] = wd;
    @(negedge clk);
    check_eq("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check_eq("out_pc", out_pc, m_pc);
      check_eq("out_rs1_data", out_rs1_data, m_rs1);
      check_eq("out_rs2_data", out_rs2_data, m_rs2);
      check_eq("out_imm", out_imm, m_imm);
      check_eq("out_rd", out_rd, m_rd);
      check_eq("out_rd_we", out_rd_we, m_we);
      check_eq("out_opcode", out_opcode, m_opc);
      check_eq("out_funct3", out_funct3, m_f3);
      check_eq("out_funct7", out_funct7, m_f7);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_busy = 0;
    m_rd = 0; m_opc = 0; m_f3 = 0; m_f7 = 0;
  endtask

  initial begin
    logic        rdy, fired, done;
    logic [31:0] ins, imm, wd;
    logic [4:0]  wr;
    int          fire_at;
    int          q[$];

    rf_mem[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    aresetn = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
    wb_en = 0; wb_reg = 0; wb_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_imm", out_imm, 0);
    check_eq("rst_out_rd", out_rd, 0);
    check_eq("rst_out_rd_we", out_rd_we, 0);
    check_eq("rst_out_rs1", out_rs1_data, 0);
    aresetn = 1'b1;

    // ADDI x1,x0,5
    step(1, enc(OPC_OP_IMM, 1, 0, 0, 0, 0, 5), 5, 32'h100, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_imm", out_imm, 5);
    check_eq("t1_rd", out_rd, 1);
    check_eq("t1_rd_we", out_rd_we, 1);

    // ADD x3,x1,x2 stalls on x1 until writeback
    ins = enc(OPC_OP, 3, 0, 1, 2, 0, 0);
    step(1, ins, 0, 32'h104, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t2_stall", rdy, 0);
    done = 0; fire_at = 0;
    for (int k = 1; k <= 3; k++) begin
      if (!done) begin
        step(1, ins, 0, 32'h104, 1, 0, k == 1, 1, 5, rdy, fired);
        if (fired) begin done = 1; fire_at = k; end
      end
    end
    check_eq("t2_issue_cycle", fire_at, BYPASS ? 1 : 2);
    check_eq("t2_rs1_data", out_rs1_data, 5);

    // Backpressure: ADD x3 held for three cycles
    ins = enc(OPC_OP_IMM, 10, 0, 0, 0, 0, 7);
    for (int k = 0; k < 3; k++) begin
      step(1, ins, 7, 32'h108, 0, 0, 0, 0, 0, rdy, fired);
      check_eq("t3_hold_ready", rdy, 0);
      check_eq("t3_hold_rd", out_rd, 3);
    end
    step(1, ins, 7, 32'h108, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t3_load_rd", out_rd, 10);
    check_eq("t3_load_imm", out_imm, 7);

    // BEQ x0,x0,-8 then SW x5,4(x6); neither sets busy on its rd field
    step(1, enc(OPC_BRANCH, 0, 0, 0, 0, 0, 32'hFFFF_FFF8), 32'hFFFF_FFF8, 32'h10c, 1, 0, 0, 0, 0,
         rdy, fired);
    check_eq("t4_beq_imm", out_imm, 32'hFFFF_FFF8);
    check_eq("t4_beq_we", out_rd_we, 0);
    step(1, enc(OPC_OP_IMM, 11, 0, 25, 0, 0, 1), 1, 32'h110, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t4_beq_nobusy", rdy, 1);
    step(1, enc(OPC_STORE, 0, 2, 6, 5, 0, 4), 4, 32'h114, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t4_sw_imm", out_imm, 4);
    check_eq("t4_sw_we", out_rd_we, 0);
    step(1, enc(OPC_OP_IMM, 12, 0, 4, 0, 0, 1), 1, 32'h118, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t4_sw_nobusy", rdy, 1);

    // Flush squashes ADDI x7 and releases its busy bit
    step(1, enc(OPC_OP_IMM, 7, 0, 0, 0, 0, 3), 3, 32'h11c, 1, 0, 0, 0, 0, rdy, fired);
    ins = enc(OPC_OP, 8, 0, 7, 7, 0, 0);
    step(1, ins, 0, 32'h120, 0, 1, 0, 0, 0, rdy, fired);
    check_eq("t5_flush_ready", rdy, 0);
    check_eq("t5_flush_valid", out_valid, 0);
    step(1, ins, 0, 32'h120, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t5_after_flush", rdy, 1);

    // x0 never busy; same-cycle set and clear of x4 leaves it busy
    step(1, enc(OPC_OP_IMM, 0, 0, 0, 0, 0, 1), 1, 32'h124, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t6_x0_we", out_rd_we, 0);
    step(1, enc(OPC_OP, 13, 0, 0, 0, 0, 0), 0, 32'h128, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t6_x0_nobusy", rdy, 1);
    step(1, enc(OPC_OP_IMM, 4, 0, 0, 0, 0, 1), 1, 32'h12c, 1, 0, 1, 4, 32'h55, rdy, fired);
    check_eq("t6_x4_fire", rdy, 1);
    ins = enc(OPC_OP, 14, 0, 4, 0, 0, 0);
    step(1, ins, 0, 32'h130, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("t6_x4_busy", rdy, 0);

    // Asynchronous reset with an entry held
    step(1, enc(OPC_OP_IMM, 21, 0, 0, 0, 0, 9), 9, 32'h134, 0, 0, 0, 0, 0, rdy, fired);
    in_valid = 0;
    #2 aresetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_rd", out_rd, 0);
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    step(1, ins, 0, 32'h138, 1, 0, 0, 0, 0, rdy, fired);
    check_eq("mid_rst_busy_clr", rdy, 1);

    // Randomized traffic; writebacks retire registers that are currently busy
    for (int n = 0; n < 1500; n++) begin
      gen_rand(ins, imm);
      q.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
      wr = 0; wd = $urandom;
      if (q.size() > 0 && $urandom_range(0, 2) != 0) wr = 5'(q[$urandom_range(0, q.size() - 1)]);
      step($urandom_range(0, 3) != 0, ins, imm, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, wr != 0, wr, wd, rdy, fired);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
